// File: rtl/snake_pkg.sv
// snake_pkg: shared playfield defaults, coordinate types and food-generator state encoding.
`default_nettype none

package snake_pkg;

  localparam int c_GRID_W_DEFAULT = 32;
  localparam int c_GRID_H_DEFAULT = 24;
  localparam int c_X_W_DEFAULT    = 5;
  localparam int c_Y_W_DEFAULT    = 5;

  typedef logic [c_X_W_DEFAULT-1:0] cell_x_t;
  typedef logic [c_Y_W_DEFAULT-1:0] cell_y_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAW       = 3'd1,
    ST_CHECK      = 3'd2,
    ST_SCAN       = 3'd3,
    ST_SCAN_CHECK = 3'd4,
    ST_FINISH     = 3'd5
  } food_gen_state_t;

endpackage

`default_nettype wire

// File: rtl/food_generator_grid_cursor.sv
// grid_cursor: x/y raster cursor over the playfield with wrap-around, load-at-next-cell and
// a flag marking the last not-yet-visited cell of a full sweep.
`default_nettype none

module grid_cursor #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int X_W    = 5,
  parameter int Y_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [X_W-1:0] i_from_x,
  input  logic [Y_W-1:0] i_from_y,
  input  logic           i_step,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  localparam int                 c_CELLS    = GRID_W * GRID_H;
  localparam int                 c_CNT_W    = $clog2(c_CELLS + 1);
  localparam logic [X_W-1:0]     c_X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]     c_Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CELLS - 1);

  logic [c_CNT_W-1:0] r_count;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [X_W-1:0]     w_base_x;
  logic [Y_W-1:0]     w_base_y;
  logic [X_W-1:0]     w_next_x;
  logic [Y_W-1:0]     w_next_y;

  // A load starts the sweep at the cell after the supplied one.
  assign w_base_x = i_load ? i_from_x : r_x;
  assign w_base_y = i_load ? i_from_y : r_y;

  always_comb begin
    w_next_x = w_base_x + 1'b1;
    w_next_y = w_base_y;
    if (w_base_x == c_X_MAX) begin
      w_next_x = '0;
      w_next_y = (w_base_y == c_Y_MAX) ? '0 : w_base_y + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_x     <= w_next_x;
      r_y     <= w_next_y;
      r_count <= '0;
    end else if (i_step) begin
      r_x <= w_next_x;
      r_y <= w_next_y;
      if (r_count != c_CNT_LAST) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_count == c_CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/food_generator.sv
// food_generator: draws random candidate cells, checks them against body occupancy and places food.
// Optional FOOD_GEN_SCAN_FALLBACK_EN adds a linear scan of the grid after MAX_TRIES failed draws.
`default_nettype none

module food_generator
  import snake_pkg::*;
#(
  parameter int GRID_W    = c_GRID_W_DEFAULT,
  parameter int GRID_H    = c_GRID_H_DEFAULT,
  parameter int X_W       = c_X_W_DEFAULT,
  parameter int Y_W       = c_Y_W_DEFAULT,
  parameter int RAND_W    = 32,
  parameter int MAX_TRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] i_random_number,
  input  logic              i_request,
  input  logic              i_occupied,
  output logic [X_W-1:0]    o_query_x,
  output logic [Y_W-1:0]    o_query_y,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_food_valid,
  output logic [X_W-1:0]    o_food_x,
  output logic [Y_W-1:0]    o_food_y,
  output logic              o_grid_full
);

  localparam int                   c_TRIES_W   = $clog2(MAX_TRIES + 1);
  localparam logic [c_TRIES_W-1:0] c_MAX_TRIES = c_TRIES_W'(MAX_TRIES);
  localparam logic [X_W:0]         c_GRID_W_X  = (X_W + 1)'(GRID_W);
  localparam logic [Y_W:0]         c_GRID_H_Y  = (Y_W + 1)'(GRID_H);

  food_gen_state_t      r_state;
  logic [c_TRIES_W-1:0] r_tries;
  logic [c_TRIES_W-1:0] w_tries_inc;
  logic                 w_exhaust;
  logic [X_W-1:0]       w_cand_x;
  logic [Y_W-1:0]       w_cand_y;
  logic                 w_in_range;
  logic                 w_unused_rand;

  assign w_cand_x      = i_random_number[X_W-1:0];
  assign w_cand_y      = i_random_number[X_W+Y_W-1:X_W];
  // Out-of-range draws are discarded rather than folded, keeping the cell distribution uniform.
  assign w_in_range    = ({1'b0, w_cand_x} < c_GRID_W_X) && ({1'b0, w_cand_y} < c_GRID_H_Y);
  assign w_tries_inc   = r_tries + 1'b1;
  assign w_exhaust     = (w_tries_inc == c_MAX_TRIES);
  assign w_unused_rand = ^i_random_number;

`ifdef FOOD_GEN_SCAN_FALLBACK_EN
  logic [X_W-1:0] w_cur_x;
  logic [Y_W-1:0] w_cur_y;
  logic           w_cur_last;
  logic           w_cur_load;
  logic           w_cur_step;

  assign w_cur_load = w_exhaust && (((r_state == ST_DRAW) && !w_in_range) ||
                                    ((r_state == ST_CHECK) && i_occupied));
  assign w_cur_step = (r_state == ST_SCAN_CHECK) && i_occupied && !w_cur_last;

  grid_cursor #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_grid_cursor (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_cur_load),
    .i_from_x (o_query_x),
    .i_from_y (o_query_y),
    .i_step   (w_cur_step),
    .o_x      (w_cur_x),
    .o_y      (w_cur_y),
    .o_last   (w_cur_last)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tries      <= '0;
      o_query_x    <= '0;
      o_query_y    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_food_valid <= 1'b0;
      o_food_x     <= '0;
      o_food_y     <= '0;
      o_grid_full  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_request) begin
            o_food_valid <= 1'b0;
            o_grid_full  <= 1'b0;
            r_tries      <= '0;
            o_busy       <= 1'b1;
            r_state      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (w_in_range) begin
            o_query_x <= w_cand_x;
            o_query_y <= w_cand_y;
            r_state   <= ST_CHECK;
          end else begin
            r_tries <= w_tries_inc;
            if (w_exhaust) begin
`ifdef FOOD_GEN_SCAN_FALLBACK_EN
              r_state <= ST_SCAN;
`else
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= ST_FINISH;
`endif
            end
          end
        end
        ST_CHECK: begin
          if (!i_occupied) begin
            o_food_x     <= o_query_x;
            o_food_y     <= o_query_y;
            o_food_valid <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            r_state      <= ST_FINISH;
          end else begin
            r_tries <= w_tries_inc;
            if (w_exhaust) begin
`ifdef FOOD_GEN_SCAN_FALLBACK_EN
              r_state <= ST_SCAN;
`else
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= ST_FINISH;
`endif
            end else begin
              r_state <= ST_DRAW;
            end
          end
        end
`ifdef FOOD_GEN_SCAN_FALLBACK_EN
        ST_SCAN: begin
          o_query_x <= w_cur_x;
          o_query_y <= w_cur_y;
          r_state   <= ST_SCAN_CHECK;
        end
        ST_SCAN_CHECK: begin
          if (!i_occupied) begin
            o_food_x     <= o_query_x;
            o_food_y     <= o_query_y;
            o_food_valid <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b1;
            r_state      <= ST_FINISH;
          end else if (w_cur_last) begin
            o_grid_full <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            r_state     <= ST_FINISH;
          end else begin
            r_state <= ST_SCAN;
          end
        end
`endif
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
